// File: rtl/sevenseg_pkg.sv
// Seven-segment pattern constants (active-low, bit6=a .. bit0=g) shared by the display encoder and the scan capture.
package sevenseg_pkg;

    localparam int SEG_A_BIT = 6;
    localparam int SEG_B_BIT = 5;
    localparam int SEG_C_BIT = 4;
    localparam int SEG_D_BIT = 3;
    localparam int SEG_E_BIT = 2;
    localparam int SEG_F_BIT = 1;
    localparam int SEG_G_BIT = 0;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/sevenseg_pattern_decode.sv
// Exact-match decode of an active-low segment pattern to a hex nibble; purely combinational, no flow control.
module sevenseg_pattern_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       blank,
    output logic       err
);

    always_comb begin
        nibble = 4'h0;
        blank  = 1'b0;
        err    = 1'b0;
        case (pattern)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_A:     nibble = 4'hA;
            SEG_B:     nibble = 4'hB;
            SEG_C:     nibble = 4'hC;
            SEG_D:     nibble = 4'hD;
            SEG_E:     nibble = 4'hE;
            SEG_F:     nibble = 4'hF;
            SEG_BLANK: blank  = 1'b1;
            default:   err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_capture.sv
// Captures a scanned seven-segment display into frames; frame out 1 cycle after the completing digit capture.
// Frames completing while out_valid is stalled are dropped and flagged via sticky overrun.
module sevenseg_scan_capture
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    output logic [4*NUM_DIGITS-1:0] out_value,
    output logic [NUM_DIGITS-1:0]   out_blank,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun,
    output logic                    decode_err
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [6:0]              seg_q;
    logic [6:0]              seg_prev;
    logic [NUM_DIGITS-1:0]   an_q;
    logic [NUM_DIGITS-1:0]   an_prev;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_next;
    logic [NUM_DIGITS-1:0]   done;
    logic [NUM_DIGITS-1:0]   mask;
    logic [4*NUM_DIGITS-1:0] stage_value;
    logic [NUM_DIGITS-1:0]   stage_blank;
    logic [NUM_DIGITS-1:0]   act;
    logic                    one_hot;
    logic                    changed;
    logic                    capture;
    logic                    frame_done;
    logic                    load;
    logic [IDX_W-1:0]        idx;
    logic [3:0]              dec_nibble;
    logic                    dec_blank;
    logic                    dec_err;

    sevenseg_pattern_decode u_decode (
        .pattern (seg_q),
        .nibble  (dec_nibble),
        .blank   (dec_blank),
        .err     (dec_err)
    );

    assign act        = ~an_q;
    assign one_hot    = (act != '0) && ((act & (act - NUM_DIGITS'(1))) == '0);
    assign changed    = {an_q, seg_q} != {an_prev, seg_prev};
    assign frame_done = &mask;
    assign load       = frame_done && (!out_valid || out_ready);

    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (act[i]) idx = IDX_W'(i);
        end

        cnt_next = cnt;
        if (!one_hot || changed)
            cnt_next = '0;
        else if (cnt != CNT_MAX)
            cnt_next = cnt + CNT_W'(1);

        // done[] keeps a saturated counter from re-firing on the same steady digit
        capture = one_hot && !changed && (cnt_next == CNT_MAX) && !done[idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q       <= '0;
            seg_prev    <= '0;
            an_q        <= '0;
            an_prev     <= '0;
            cnt         <= '0;
            done        <= '0;
            mask        <= '0;
            stage_value <= '0;
            stage_blank <= '0;
            out_value   <= '0;
            out_blank   <= '0;
            out_valid   <= 1'b0;
            overrun     <= 1'b0;
            decode_err  <= 1'b0;
        end else begin
            seg_q    <= seg_n;
            an_q     <= an_n;
            seg_prev <= seg_q;
            an_prev  <= an_q;
            cnt      <= cnt_next;

            if (!one_hot || changed)
                done <= '0;
            else if (capture)
                done[idx] <= 1'b1;

            if (capture && dec_err)
                decode_err <= 1'b1;

            if (capture && !dec_err) begin
                stage_value[4*idx +: 4] <= dec_nibble;
                stage_blank[idx]        <= dec_blank;
            end

            if (frame_done) begin
                mask <= '0;
                if (!load)
                    overrun <= 1'b1;
            end else if (capture && !dec_err) begin
                mask[idx] <= 1'b1;
            end

            if (load) begin
                out_value <= stage_value;
                out_blank <= stage_blank;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
